ber_phase_scan: RTL and testbench
=================================

Name: ber_phase_scan

Overview:
- Sequencer that drives the DSP chain's reset, enables and phase select to run an automatic BER phase scan.
- For each of the 2^NB_PHASE phases it:
  - waits a settle time,
  - measures errors over a programmed bit window, using baseline-subtracted counter deltas.
- After the scan it selects the minimum-error phase and leaves TX/RX/BER running on it.
- It sits between the register file (start/abort/window, result readback) and the dsp block (rst, enables, phase, real-branch counters).

Parameters:
- NB_COUNT, 64, width of bit/error counters and window.
- NB_PHASE, 2, phase select width; the scan covers 2^NB_PHASE phases.
- RESET_CYCLES, 16, cycles the dsp reset is held at scan start.
- SETTLE_CYCLES, 1024, cycles waited after each phase change before measuring.
- NB_TIMER, 32, width of the internal cycle timer.
- TIMEOUT_CYCLES, 2^24, maximum MEASURE duration per phase (optional feature only).

Ports:
- clk  in  1  system DSP clock
- rst  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle start pulse
- i_abort  in  1  one-cycle abort pulse
- i_window  in  NB_COUNT  bits to measure per phase; sampled on accepted start
- i_bit_count  in  NB_COUNT  dsp real-branch bit counter, free-running, wraps
- i_error_count  in  NB_COUNT  dsp real-branch error counter, free-running, wraps
- o_dsp_rst  out  1  active-high reset to dsp
- o_enable  out  3  [0] tx, [1] rx, [2] ber
- o_phase  out  NB_PHASE  phase select to dsp
- o_busy  out  1  scan in progress
- o_done  out  1  scan complete, result valid; sticky until next start
- o_best_phase  out  NB_PHASE  selected phase
- o_min_errors  out  NB_COUNT  error delta of selected phase
- o_timeout  out  1  at least one phase timed out (optional feature; else tied 0)

Behaviour:
- Reset (rst=0, asynchronous):
  - state IDLE; o_dsp_rst=1, o_enable=0, o_phase=0, o_busy=0, o_done=0, o_best_phase=0, o_min_errors=all-ones, o_timeout=0.
  - All outputs are registered.
- States: IDLE, RST_DSP, SETTLE, MEASURE, CAPTURE, NEXT, LOCK.
- IDLE:
  - i_start=1 latches the window (0 is replaced by 1), clears o_done/o_timeout, sets o_min_errors=all-ones, o_best_phase=0, o_phase=0, o_busy=1, o_dsp_rst=1, o_enable=0 → RST_DSP.
  - i_start is ignored in every other state.
- RST_DSP: hold o_dsp_rst=1 for exactly RESET_CYCLES cycles. Then o_dsp_rst=0, o_enable=3'b011 → SETTLE.
- SETTLE:
  - Count SETTLE_CYCLES cycles.
  - On exit, latch base_bits=i_bit_count and base_err=i_error_count, set o_enable[2]=1 → MEASURE.
- MEASURE:
  - Each cycle compute d_bits = i_bit_count - base_bits and d_err = i_error_count - base_err, modulo 2^NB_COUNT, so counter wrap is handled.
  - When d_bits >= window → CAPTURE, with d_err registered that cycle.
- CAPTURE (1 cycle):
  - If d_err < o_min_errors (strict), update o_min_errors=d_err and o_best_phase=o_phase.
  - Ties keep the lower phase.
  - Then clear o_enable[2] → NEXT.
- NEXT (1 cycle):
  - If o_phase is the last phase (all-ones) → LOCK.
  - Otherwise o_phase+1 → SETTLE.
- LOCK: o_phase=o_best_phase, o_enable=3'b111, o_busy=0, o_done=1 → IDLE. Enables and phase persist in IDLE.
- Abort:
  - i_abort=1 in any busy state → IDLE next cycle with o_enable=0, o_dsp_rst=1, o_busy=0, o_done=0.
  - Results are left as partially updated.
  - i_abort in IDLE has no effect.
- Simultaneous i_start and i_abort in IDLE: start wins.
- Latency with no timeouts: RESET_CYCLES + 2^NB_PHASE × (SETTLE_CYCLES + measure + 2) + 1 cycles.

Optional Feature:
- Macro PHASE_SCAN_TIMEOUT_EN.
- Defined:
  - A MEASURE timer counts cycles.
  - Reaching TIMEOUT_CYCLES forces CAPTURE with d_err treated as all-ones (saturated) and sets sticky o_timeout=1.
  - If every phase times out, o_best_phase=0 and o_min_errors=all-ones.
- Not defined: MEASURE waits indefinitely for the bit window and o_timeout is constant 0.

Test Plan:
- Reset release, then start with i_window=1000; counter model adds 1 bit/cycle and errors of 50/10/10/80 for phases 0..3 → o_best_phase=1 (tie goes to lower), o_min_errors=10, o_done=1, o_enable=3'b111, o_phase=1.
- Start issued with base i_bit_count=2^64-200 and window 1000 → counters wrap, delta is computed correctly, measure completes after 1000 bits.
- Abort during phase 2 SETTLE → next cycle o_busy=0, o_dsp_rst=1, o_enable=0, o_done=0; a second i_start while busy in an earlier run is ignored.
- i_window=0 → treated as 1; each MEASURE ends on the first cycle the bit delta is ≥1.
- With PHASE_SCAN_TIMEOUT_EN and TIMEOUT_CYCLES=100, phase 3 bit counter frozen → o_timeout=1 and phase 3 never selected; all phases frozen → best 0, min all-ones.
- rst asserted mid-MEASURE → outputs immediately at reset values; after release, a new start runs a clean full scan.

Source files
------------

// File: rtl/ber_phase_scan.sv
// Purpose : sequences dsp reset/enables/phase through a full BER phase scan and locks onto the min-error phase.
// Latency : RESET_CYCLES + 2^NB_PHASE*(SETTLE_CYCLES + measure + 2) + 1 cycles from accepted start to o_done.
// Backpr. : none; start is ignored while busy, abort returns to IDLE next cycle. Optional: PHASE_SCAN_TIMEOUT_EN.
module ber_phase_scan #(
    parameter int NB_COUNT      = 64,
    parameter int NB_PHASE      = 2,
    parameter int RESET_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 1024,
    parameter int NB_TIMER      = 32
`ifdef PHASE_SCAN_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1 << 24
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [NB_COUNT-1:0] i_window,
    input  logic [NB_COUNT-1:0] i_bit_count,
    input  logic [NB_COUNT-1:0] i_error_count,
    output logic                o_dsp_rst,
    output logic [2:0]          o_enable,
    output logic [NB_PHASE-1:0] o_phase,
    output logic                o_busy,
    output logic                o_done,
    output logic [NB_PHASE-1:0] o_best_phase,
    output logic [NB_COUNT-1:0] o_min_errors,
    output logic                o_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_DSP,
        S_SETTLE,
        S_MEASURE,
        S_CAPTURE,
        S_NEXT,
        S_LOCK
    } state_t;

    localparam logic [NB_COUNT-1:0] ALL_ONES    = '1;
    localparam logic [NB_PHASE-1:0] LAST_PHASE  = '1;
    localparam logic [NB_TIMER-1:0] RST_LAST    = NB_TIMER'(RESET_CYCLES - 1);
    localparam logic [NB_TIMER-1:0] SETTLE_LAST = NB_TIMER'(SETTLE_CYCLES - 1);

    state_t              state;
    logic [NB_TIMER-1:0] timer;
    logic [NB_COUNT-1:0] window_q;
    logic [NB_COUNT-1:0] base_bits;
    logic [NB_COUNT-1:0] base_err;
    logic [NB_COUNT-1:0] cap_err;

    // Deltas are taken modulo 2^NB_COUNT so free-running counter wrap is harmless.
    logic [NB_COUNT-1:0] d_bits;
    logic [NB_COUNT-1:0] d_err;
    logic                meas_hit;
    logic                meas_tmo;

    assign d_bits   = i_bit_count - base_bits;
    assign d_err    = i_error_count - base_err;
    assign meas_hit = (d_bits >= window_q);

`ifdef PHASE_SCAN_TIMEOUT_EN
    localparam logic [NB_TIMER-1:0] TMO_LAST = NB_TIMER'(TIMEOUT_CYCLES - 1);
    // MEASURE gives up once the bit window has not filled within TIMEOUT_CYCLES cycles.
    assign meas_tmo = (timer == TMO_LAST);
`else
    // Without the timeout, MEASURE waits for the bit window indefinitely.
    assign meas_tmo = 1'b0;
`endif

    // Scan sequencer: state, cycle timer, baselines and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            timer        <= '0;
            window_q     <= NB_COUNT'(1);
            base_bits    <= '0;
            base_err     <= '0;
            cap_err      <= '0;
            o_dsp_rst    <= 1'b1;
            o_enable     <= 3'b000;
            o_phase      <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_best_phase <= '0;
            o_min_errors <= ALL_ONES;
            o_timeout    <= 1'b0;
        end else if (state != S_IDLE && i_abort) begin
            // Abort leaves result registers as they stand; dsp is parked in reset.
            state     <= S_IDLE;
            o_enable  <= 3'b000;
            o_dsp_rst <= 1'b1;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Start beats a simultaneous abort; a zero window would never measure anything.
                    if (i_start) begin
                        window_q     <= (i_window == '0) ? NB_COUNT'(1) : i_window;
                        o_done       <= 1'b0;
                        o_timeout    <= 1'b0;
                        o_min_errors <= ALL_ONES;
                        o_best_phase <= '0;
                        o_phase      <= '0;
                        o_busy       <= 1'b1;
                        o_dsp_rst    <= 1'b1;
                        o_enable     <= 3'b000;
                        timer        <= '0;
                        state        <= S_RST_DSP;
                    end
                end
                S_RST_DSP: begin
                    if (timer == RST_LAST) begin
                        timer     <= '0;
                        o_dsp_rst <= 1'b0;
                        o_enable  <= 3'b011;
                        state     <= S_SETTLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_SETTLE: begin
                    // Baselines are grabbed on the last settle cycle, as BER counting starts.
                    if (timer == SETTLE_LAST) begin
                        timer       <= '0;
                        base_bits   <= i_bit_count;
                        base_err    <= i_error_count;
                        o_enable[2] <= 1'b1;
                        state       <= S_MEASURE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_MEASURE: begin
                    if (meas_hit) begin
                        cap_err <= d_err;
                        state   <= S_CAPTURE;
                    end else if (meas_tmo) begin
                        cap_err   <= ALL_ONES;
                        o_timeout <= 1'b1;
                        state     <= S_CAPTURE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    // Strict compare: on a tie the earlier (lower) phase is kept.
                    if (cap_err < o_min_errors) begin
                        o_min_errors <= cap_err;
                        o_best_phase <= o_phase;
                    end
                    o_enable[2] <= 1'b0;
                    state       <= S_NEXT;
                end
                S_NEXT: begin
                    if (o_phase == LAST_PHASE) begin
                        state <= S_LOCK;
                    end else begin
                        o_phase <= o_phase + 1'b1;
                        timer   <= '0;
                        state   <= S_SETTLE;
                    end
                end
                S_LOCK: begin
                    // Phase and enables stay applied in IDLE so traffic keeps running.
                    o_phase  <= o_best_phase;
                    o_enable <= 3'b111;
                    o_busy   <= 1'b0;
                    o_done   <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ber_phase_scan.sv
// Bench for ber_phase_scan: dsp counter model reacting to o_phase, schedule-level reference model.
// Inputs are recorded per clock edge; expected results are derived from that record.
// Timeout scenarios only run when PHASE_SCAN_TIMEOUT_EN is defined.
module tb_ber_phase_scan;

    localparam int R = 16;
    localparam int S = 64;
`ifdef PHASE_SCAN_TIMEOUT_EN
    localparam int T = 100;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [63:0] i_window = '0;
    logic [63:0] i_bit_count = '0;
    logic [63:0] i_error_count = '0;
    logic        o_dsp_rst;
    logic [2:0]  o_enable;
    logic [1:0]  o_phase;
    logic        o_busy;
    logic        o_done;
    logic [1:0]  o_best_phase;
    logic [63:0] o_min_errors;
    logic        o_timeout;

    ber_phase_scan #(
        .NB_COUNT     (64),
        .NB_PHASE     (2),
        .RESET_CYCLES (R),
        .SETTLE_CYCLES(S),
        .NB_TIMER     (32)
`ifdef PHASE_SCAN_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(T)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_window     (i_window),
        .i_bit_count  (i_bit_count),
        .i_error_count(i_error_count),
        .o_dsp_rst    (o_dsp_rst),
        .o_enable     (o_enable),
        .o_phase      (o_phase),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_best_phase (o_best_phase),
        .o_min_errors (o_min_errors),
        .o_timeout    (o_timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Input values present at each rising edge, indexed by edge number.
    logic [63:0] qb[$];
    logic [63:0] qe[$];

    // dsp counter model: mode 0 = 1 bit/cycle, error when bit value mod 100 < k; mode 1 = random.
    int          dsp_mode = 0;
    int          k_rate[4];
    bit          frozen[4];
    logic [63:0] bits_cnt = '0;
    logic [63:0] err_cnt = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        int p;
        qb.push_back(i_bit_count);
        qe.push_back(i_error_count);
        @(posedge clk);
        #1;
        p = int'(o_phase);
        if (dsp_mode == 0) begin
            if (!frozen[p]) begin
                bits_cnt = bits_cnt + 64'd1;
                if ((bits_cnt % 64'd100) < 64'(k_rate[p])) err_cnt = err_cnt + 64'd1;
            end
        end else begin
            if (!frozen[p]) bits_cnt = bits_cnt + 64'($urandom_range(0, 3));
            err_cnt = err_cnt + 64'($urandom_range(0, k_rate[p]));
        end
        i_bit_count   = bits_cnt;
        i_error_count = err_cnt;
    endtask

    // Scan reference: each phase latches a baseline after settling, measures until the
    // bit delta reaches the window (or times out), then spends 2 cycles before the next settle.
    function automatic void predict(input int s0, input logic [63:0] win,
                                    output logic [1:0] best, output logic [63:0] mn,
                                    output int done_e, output bit tmo);
        logic [63:0] w, bb, be, d;
        int base, e, last_e;
        w = (win == 64'd0) ? 64'd1 : win;
        best = 2'd0; mn = '1; tmo = 1'b0; done_e = -1; d = '0; last_e = -1;
        base = s0 + R + S;
        for (int p = 0; p < 4; p++) begin
            if (base >= qb.size()) return;
            bb = qb[base];
            be = qe[base];
            e = base + 1;
            while (1) begin
                if (e >= qb.size()) return;
                if (qb[e] - bb >= w) begin
                    d = qe[e] - be;
                    break;
                end
`ifdef PHASE_SCAN_TIMEOUT_EN
                if (e - base == T) begin
                    d = '1;
                    tmo = 1'b1;
                    break;
                end
`endif
                e++;
            end
            if (d < mn) begin
                mn = d;
                best = 2'(p);
            end
            last_e = e;
            base = e + 2 + S;
        end
        done_e = last_e + 3;
    endfunction

    task automatic check_reset_vals(input string tag);
        check_val({tag, ".dsp_rst"}, 64'(o_dsp_rst), 64'd1);
        check_val({tag, ".enable"}, 64'(o_enable), 64'd0);
        check_val({tag, ".phase"}, 64'(o_phase), 64'd0);
        check_val({tag, ".busy"}, 64'(o_busy), 64'd0);
        check_val({tag, ".done"}, 64'(o_done), 64'd0);
        check_val({tag, ".best"}, 64'(o_best_phase), 64'd0);
        check_val({tag, ".min"}, o_min_errors, '1);
        check_val({tag, ".tmo"}, 64'(o_timeout), 64'd0);
    endtask

    task automatic run_scan(input string tag, input logic [63:0] win, input bit poke_start,
                            input bit with_abort, output int lat);
        int s0, done_edge, rst_fall, exp_done;
        logic [1:0] exp_best;
        logic [63:0] exp_min;
        bit exp_tmo;
        i_window = win;
        i_start = 1'b1;
        i_abort = with_abort;
        s0 = qb.size();
        tick();
        i_start = 1'b0;
        i_abort = 1'b0;
        i_window = {32'($urandom), 32'($urandom)};
        check_val({tag, ".busy_on_start"}, 64'(o_busy), 64'd1);
        rst_fall = -1;
        done_edge = -1;
        for (int b = 0; b < 20000 && done_edge < 0; b++) begin
            if (poke_start && b == 300) begin
                i_start = 1'b1;
                i_window = 64'd5;
            end
            tick();
            i_start = 1'b0;
            if (rst_fall < 0 && !o_dsp_rst) rst_fall = qb.size() - 1;
            if (o_done) done_edge = qb.size() - 1;
        end
        predict(s0, win, exp_best, exp_min, exp_done, exp_tmo);
        check_val({tag, ".rst_fall"}, 64'(rst_fall), 64'(s0 + R));
        check_val({tag, ".done_edge"}, 64'(done_edge), 64'(exp_done));
        check_val({tag, ".best"}, 64'(o_best_phase), 64'(exp_best));
        check_val({tag, ".min"}, o_min_errors, exp_min);
        check_val({tag, ".phase"}, 64'(o_phase), 64'(exp_best));
        check_val({tag, ".enable"}, 64'(o_enable), 64'd7);
        check_val({tag, ".busy"}, 64'(o_busy), 64'd0);
        check_val({tag, ".tmo"}, 64'(o_timeout), 64'(exp_tmo));
        lat = done_edge - s0;
    endtask

    initial begin
        int lat;
        int waited;
        for (int p = 0; p < 4; p++) frozen[p] = 1'b0;
        k_rate[0] = 5; k_rate[1] = 1; k_rate[2] = 1; k_rate[3] = 8;

        // Reset state
        repeat (3) tick();
        check_reset_vals("reset");
        rst = 1'b1;
        repeat (2) tick();

        // Directed scan: errors 50/10/10/80, tie resolves to phase 1; second start ignored
        run_scan("scan1", 64'd1000, 1'b1, 1'b0, lat);
        check_val("scan1.best_const", 64'(o_best_phase), 64'd1);
        check_val("scan1.min_const", o_min_errors, 64'd10);
        check_val("scan1.latency", 64'(lat), 64'(R + 4 * (S + 1000 + 2) + 1));

        // Counter wrap during measurement
        bits_cnt = 64'hFFFF_FFFF_FFFF_FFFF - 64'd199;
        i_bit_count = bits_cnt;
        run_scan("wrap", 64'd1000, 1'b0, 1'b0, lat);
        check_val("wrap.latency", 64'(lat), 64'(R + 4 * (S + 1000 + 2) + 1));

        // Zero window behaves as one bit
        run_scan("win0", 64'd0, 1'b0, 1'b0, lat);
        check_val("win0.latency", 64'(lat), 64'(R + 4 * (S + 1 + 2) + 1));

        // Abort during phase 2 settle
        dsp_mode = 1;
        i_window = 64'd200;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        waited = 0;
        while (o_phase != 2'd2 && waited < 5000) begin
            tick();
            waited++;
        end
        check_val("abort.reach_phase2", 64'(o_phase), 64'd2);
        repeat (5) tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check_val("abort.busy", 64'(o_busy), 64'd0);
        check_val("abort.dsp_rst", 64'(o_dsp_rst), 64'd1);
        check_val("abort.enable", 64'(o_enable), 64'd0);
        check_val("abort.done", 64'(o_done), 64'd0);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check_val("abort_idle.busy", 64'(o_busy), 64'd0);
        check_val("abort_idle.dsp_rst", 64'(o_dsp_rst), 64'd1);

        // Randomized scans; one starts together with an abort (start wins)
        for (int n = 0; n < 6; n++) begin
            for (int p = 0; p < 4; p++) k_rate[p] = $urandom_range(0, 6);
            run_scan($sformatf("rand%0d", n), 64'($urandom_range(0, 400)), 1'b0, n == 2, lat);
        end

        // Reset asserted mid-measure, then a clean scan
        i_window = 64'd1000;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (R + S + 20) tick();
        rst = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        run_scan("after_rst", 64'd300, 1'b0, 1'b0, lat);

`ifdef PHASE_SCAN_TIMEOUT_EN
        // Phase 3 starved of bits: times out and is never chosen
        frozen[3] = 1'b1;
        run_scan("tmo_p3", 64'd50, 1'b0, 1'b0, lat);
        check_val("tmo_p3.flag", 64'(o_timeout), 64'd1);
        // Every phase starved: defaults survive
        for (int p = 0; p < 4; p++) frozen[p] = 1'b1;
        run_scan("tmo_all", 64'd50, 1'b0, 1'b0, lat);
        check_val("tmo_all.best_const", 64'(o_best_phase), 64'd0);
        check_val("tmo_all.min_const", o_min_errors, '1);
        check_val("tmo_all.latency", 64'(lat), 64'(R + 4 * (S + T + 2) + 1));
        for (int p = 0; p < 4; p++) frozen[p] = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
